// File: rtl/calibration_pkg.sv
// Shared definitions for the LED calibration pattern generator and the capture side.
// Contents: pattern FSM state enum and the default 0/1 bit colours.
package calibration_pkg;

  typedef enum logic [2:0] {
    CAL_IDLE,
    CAL_STREAM,
    CAL_WAIT_LATCH,
    CAL_SHOWING,
    CAL_DONE
  } calibration_pattern_state_t;

  // Red marks a 0 bit, green marks a 1 bit.
  localparam logic [23:0] CAL_COLOR_0_DEFAULT = 24'hFF0000;
  localparam logic [23:0] CAL_COLOR_1_DEFAULT = 24'h00FF00;

endpackage

// File: rtl/calibration_pattern_gen.sv
// Binary-coded LED calibration pattern generator.
// For each address bit in turn, every LED shows COLOR_1 if that bit of its index
// is 1 and COLOR_0 otherwise. The camera captures one frame per bit and rebuilds
// each LED's index from the sequence of colours it saw.
// Ports:
//   clk_pixel, rst           - clock, asynchronous active-high reset
//   start_step               - level; a 0->1 edge requests the next step
//   restart                  - synchronous return to IDLE with bit_index 0
//   color_ready              - strand driver accepts color_out/led_index_out
//   strand_done              - one-cycle pulse: driver latched the whole frame
//   color_out, led_index_out - colour and LED index offered to the driver
//   color_valid              - offer valid
//   displayed_frame_valid    - pattern for bit_index is on the strand
//   should_overwrite         - first step, capture side must overwrite its RAM
//   bit_index                - address bit shown by the current step
//   calibration_done         - all steps shown
module calibration_pattern_gen
  import calibration_pkg::*;
#(
  parameter int unsigned NUM_LEDS          = 50,
  parameter int unsigned LED_ADDRESS_WIDTH = 10,
  parameter logic [23:0] COLOR_0           = CAL_COLOR_0_DEFAULT,
  parameter logic [23:0] COLOR_1           = CAL_COLOR_1_DEFAULT,
  localparam int unsigned NUM_BITS         = $clog2(NUM_LEDS),
  localparam int unsigned BIT_W            = $clog2(NUM_BITS + 1)
) (
  input  logic                         clk_pixel,
  input  logic                         rst,
  input  logic                         start_step,
  input  logic                         restart,
  input  logic                         color_ready,
  input  logic                         strand_done,
  output logic [23:0]                  color_out,
  output logic [LED_ADDRESS_WIDTH-1:0] led_index_out,
  output logic                         color_valid,
  output logic                         displayed_frame_valid,
  output logic                         should_overwrite,
  output logic [BIT_W-1:0]             bit_index,
  output logic                         calibration_done
);

  localparam logic [LED_ADDRESS_WIDTH-1:0] LAST_LED = LED_ADDRESS_WIDTH'(NUM_LEDS - 1);
  localparam logic [LED_ADDRESS_WIDTH-1:0] LED_ONE  = LED_ADDRESS_WIDTH'(1);
  localparam logic [BIT_W-1:0]             LAST_BIT = BIT_W'(NUM_BITS - 1);
  localparam logic [BIT_W-1:0]             BIT_ONE  = BIT_W'(1);

  calibration_pattern_state_t   state;
  logic [LED_ADDRESS_WIDTH-1:0] led_count;
  logic                         start_q;
  logic                         start_rise_c;

  // Only a 0->1 transition of the level input requests a step.
  assign start_rise_c = start_step & ~start_q;

  // The offered index is the LED counter itself.
  assign led_index_out = led_count;

  // Colour for one LED: selected by the chosen address bit of its index.
  function automatic logic [23:0] pattern_color(input logic [LED_ADDRESS_WIDTH-1:0] led,
                                                input logic [BIT_W-1:0]             bit_sel);
    logic [LED_ADDRESS_WIDTH-1:0] shifted;
    shifted = led >> bit_sel;
    return shifted[0] ? COLOR_1 : COLOR_0;
  endfunction

  // Step sequencer with registered outputs.
  always_ff @(posedge clk_pixel or posedge rst) begin
    if (rst) begin
      state                 <= CAL_IDLE;
      led_count             <= '0;
      start_q               <= 1'b0;
      bit_index             <= '0;
      color_out             <= '0;
      color_valid           <= 1'b0;
      displayed_frame_valid <= 1'b0;
      should_overwrite      <= 1'b1;
      calibration_done      <= 1'b0;
    end else begin
      // Edge register always tracks the input, so a rising edge coincident
      // with restart is consumed rather than held over.
      start_q <= start_step;

      if (restart) begin
        state                 <= CAL_IDLE;
        led_count             <= '0;
        bit_index             <= '0;
        color_out             <= '0;
        color_valid           <= 1'b0;
        displayed_frame_valid <= 1'b0;
        should_overwrite      <= 1'b1;
        calibration_done      <= 1'b0;
      end else begin
        case (state)
          CAL_IDLE: begin
            if (start_rise_c) begin
              state       <= CAL_STREAM;
              led_count   <= '0;
              color_valid <= 1'b1;
              color_out   <= pattern_color('0, bit_index);
            end
          end

          CAL_STREAM: begin
            if (color_valid && color_ready) begin
              if (led_count == LAST_LED) begin
                state       <= CAL_WAIT_LATCH;
                color_valid <= 1'b0;
              end else begin
                led_count <= led_count + LED_ONE;
                color_out <= pattern_color(led_count + LED_ONE, bit_index);
              end
            end
          end

          CAL_WAIT_LATCH: begin
            if (strand_done) begin
              state                 <= CAL_SHOWING;
              displayed_frame_valid <= 1'b1;
            end
          end

          CAL_SHOWING: begin
            if (start_rise_c) begin
              displayed_frame_valid <= 1'b0;
              if (bit_index < LAST_BIT) begin
                state            <= CAL_STREAM;
                bit_index        <= bit_index + BIT_ONE;
                led_count        <= '0;
                color_valid      <= 1'b1;
                color_out        <= pattern_color('0, bit_index + BIT_ONE);
                should_overwrite <= 1'b0;
              end else begin
                state            <= CAL_DONE;
                calibration_done <= 1'b1;
              end
            end
          end

          CAL_DONE: begin
            // Held until restart or reset.
          end

          default: begin
            state <= CAL_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_calibration_pattern_gen.sv
// Self-checking bench for calibration_pattern_gen (NUM_LEDS = 4, two bit steps).
// A behavioural model tracks the pattern step and LED position; a negedge
// process compares every output each cycle. Directed scenarios pin the model
// with literal expectations, then randomized stimulus runs against the model.
module tb_calibration_pattern_gen;

  localparam int unsigned N  = 4;
  localparam int unsigned NB = 2;
  localparam int unsigned AW = 10;
  localparam logic [23:0] C0 = 24'hFF0000;
  localparam logic [23:0] C1 = 24'h00FF00;

  logic          clk_pixel;
  logic          rst;
  logic          start_step;
  logic          restart;
  logic          color_ready;
  logic          strand_done;
  logic [23:0]   color_out;
  logic [AW-1:0] led_index_out;
  logic          color_valid;
  logic          displayed_frame_valid;
  logic          should_overwrite;
  logic [1:0]    bit_index;
  logic          calibration_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          idx;
    logic [23:0] col;
    int          bitn;
  } xfer_t;
  xfer_t xfers[$];

  calibration_pattern_gen #(
    .NUM_LEDS          (N),
    .LED_ADDRESS_WIDTH (AW),
    .COLOR_0           (C0),
    .COLOR_1           (C1)
  ) dut (
    .clk_pixel             (clk_pixel),
    .rst                   (rst),
    .start_step            (start_step),
    .restart               (restart),
    .color_ready           (color_ready),
    .strand_done           (strand_done),
    .color_out             (color_out),
    .led_index_out         (led_index_out),
    .color_valid           (color_valid),
    .displayed_frame_valid (displayed_frame_valid),
    .should_overwrite      (should_overwrite),
    .bit_index             (bit_index),
    .calibration_done      (calibration_done)
  );

  initial clk_pixel = 1'b0;
  always #5 clk_pixel = ~clk_pixel;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 streaming, 2 awaiting latch,
  // 3 frame on strand, 4 finished. pos = LED being offered, step = bit shown.
  int m_phase, m_pos, m_step;
  logic m_prev;

  always @(posedge clk_pixel or posedge rst) begin
    logic rise;
    if (rst) begin
      m_phase = 0; m_pos = 0; m_step = 0; m_prev = 1'b0;
    end else begin
      rise   = start_step && !m_prev;
      m_prev = start_step;
      if (restart) begin
        m_phase = 0; m_pos = 0; m_step = 0;
      end else begin
        case (m_phase)
          0: if (rise) begin m_phase = 1; m_pos = 0; end
          1: if (color_ready) begin
               if (m_pos == N - 1) m_phase = 2;
               else m_pos = m_pos + 1;
             end
          2: if (strand_done) m_phase = 3;
          3: if (rise) begin
               if (m_step < NB - 1) begin m_step = m_step + 1; m_pos = 0; m_phase = 1; end
               else m_phase = 4;
             end
          default: ;
        endcase
      end
    end
  end

  function automatic logic [23:0] model_color(input int pos, input int stp);
    return (((pos >> stp) & 1) == 1) ? C1 : C0;
  endfunction

  // Per-cycle comparison against the model, plus a log of accepted transfers.
  always @(negedge clk_pixel) begin
    if (!rst) begin
      check("color_valid", 32'(color_valid), 32'(m_phase == 1));
      check("displayed_frame_valid", 32'(displayed_frame_valid), 32'(m_phase == 3));
      check("calibration_done", 32'(calibration_done), 32'(m_phase == 4));
      check("bit_index", 32'(bit_index), 32'(m_step));
      check("should_overwrite", 32'(should_overwrite), 32'(m_step == 0));
      if (m_phase == 1) begin
        check("led_index_out", 32'(led_index_out), 32'(m_pos));
        check("color_out", 32'(color_out), 32'(model_color(m_pos, m_step)));
      end
      if (color_valid && color_ready)
        xfers.push_back('{idx: int'(led_index_out), col: color_out, bitn: int'(bit_index)});
    end
  end

  task automatic tick();
    @(posedge clk_pixel);
    #2;
  endtask

  task automatic pulse_start();
    start_step = 1'b1;
    tick();
    start_step = 1'b0;
  endtask

  task automatic pulse_done();
    strand_done = 1'b1;
    tick();
    strand_done = 1'b0;
  endtask

  // Wait for the end of the current frame stream with a cycle budget.
  task automatic wait_stream_end(input string name);
    int k;
    k = 0;
    while (color_valid && k < 40) begin
      tick();
      k++;
    end
    check({name, "_stream_timeout"}, 32'(color_valid), 32'd0);
  endtask

  task automatic check_frame(input string name, input logic [23:0] e0, input logic [23:0] e1,
                             input logic [23:0] e2, input logic [23:0] e3, input int bitn);
    logic [23:0] exp_col [4];
    exp_col[0] = e0; exp_col[1] = e1; exp_col[2] = e2; exp_col[3] = e3;
    check({name, "_count"}, 32'(xfers.size()), 32'd4);
    for (int i = 0; i < 4 && i < xfers.size(); i++) begin
      check({name, "_idx"}, 32'(xfers[i].idx), 32'(i));
      check({name, "_col"}, 32'(xfers[i].col), 32'(exp_col[i]));
      check({name, "_bit"}, 32'(xfers[i].bitn), 32'(bitn));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start_step = 1'b0; restart = 1'b0; color_ready = 1'b1; strand_done = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset values.
    check("rst_color_valid", 32'(color_valid), 32'd0);
    check("rst_should_overwrite", 32'(should_overwrite), 32'd1);
    check("rst_bit_index", 32'(bit_index), 32'd0);
    check("rst_color_out", 32'(color_out), 32'd0);

    // strand_done while idle has no effect.
    pulse_done();
    tick();
    check("idle_done_dfv", 32'(displayed_frame_valid), 32'd0);

    // Step 0, driver always ready: LEDs 0..3 -> C0,C1,C0,C1.
    xfers.delete();
    pulse_start();
    wait_stream_end("step0");
    check_frame("step0", C0, C1, C0, C1, 0);
    check("step0_overwrite", 32'(should_overwrite), 32'd1);

    // Latch pulse: frame shown from the next cycle.
    pulse_done();
    check("latch_dfv", 32'(displayed_frame_valid), 32'd1);

    // Step 1 with ready toggled 1,0,0,1: LEDs 0..3 -> C0,C0,C1,C1.
    xfers.delete();
    pulse_start();
    check("step1_dfv_drop", 32'(displayed_frame_valid), 32'd0);
    color_ready = 1'b1; tick();
    color_ready = 1'b0; tick();
    check("stall_idx_a", 32'(led_index_out), 32'd1);
    tick();
    check("stall_idx_b", 32'(led_index_out), 32'd1);
    color_ready = 1'b1;
    wait_stream_end("step1");
    check_frame("step1", C0, C0, C1, C1, 1);
    check("step1_overwrite", 32'(should_overwrite), 32'd0);

    // Final edge finishes calibration; further edges ignored.
    pulse_done();
    pulse_start();
    check("done_flag", 32'(calibration_done), 32'd1);
    tick();
    pulse_start();
    tick();
    check("done_hold", 32'(calibration_done), 32'd1);

    // Restart returns to idle.
    restart = 1'b1; tick(); restart = 1'b0;
    check("restart_done", 32'(calibration_done), 32'd0);
    check("restart_bit", 32'(bit_index), 32'd0);

    // Restart mid-stream at index 2.
    pulse_start();
    for (int k = 0; k < 20 && !(color_valid && led_index_out == 2); k++) tick();
    check("reach_idx2", 32'(led_index_out), 32'd2);
    restart = 1'b1; tick(); restart = 1'b0;
    check("restart_cv", 32'(color_valid), 32'd0);
    check("restart_bit2", 32'(bit_index), 32'd0);

    // Reach WAIT_LATCH of step 1, then async reset mid-cycle.
    pulse_start();
    wait_stream_end("pre_rst0");
    pulse_done();
    pulse_start();
    wait_stream_end("pre_rst1");
    check("pre_rst_bit", 32'(bit_index), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("arst_bit", 32'(bit_index), 32'd0);
    check("arst_overwrite", 32'(should_overwrite), 32'd1);
    check("arst_cv", 32'(color_valid), 32'd0);
    check("arst_dfv", 32'(displayed_frame_valid), 32'd0);
    check("arst_done", 32'(calibration_done), 32'd0);
    check("arst_color", 32'(color_out), 32'd0);
    check("arst_idx", 32'(led_index_out), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Randomized traffic checked by the model every cycle.
    for (int c = 0; c < 4000; c++) begin
      color_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 5) == 0) start_step = ~start_step;
      strand_done = ($urandom_range(0, 7) == 0);
      restart     = ($urandom_range(0, 199) == 0);
      rst         = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0; restart = 1'b0; start_step = 1'b0; strand_done = 1'b0;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
